// File: rtl/multi_core_debug_dispatch_if.sv
// Bundle of the debug strobe/command inputs and the per-core dispatch outputs of
// multi_core_debug_dispatch; the master side drives strobes and acknowledges.
interface multi_core_debug_dispatch_if #(
  parameter int NUM_CORES = 4,
  parameter int SR_WIDTH  = 38
);
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                  vs_udr;
  logic                  vs_uir;
  logic [1:0]            ir_in;
  logic [SR_WIDTH-1:0]   sr;
  logic [NUM_CORES-1:0]  act_ready;
  logic [NUM_CORES-1:0]  act_valid;
  logic [3:0]            act_code;
  logic [SR_WIDTH-1:0]   jdo;
  logic [CORE_W-1:0]     core_sel;
  logic                  bcast;
  logic                  busy;
  logic                  err_overrun;
  logic                  err_timeout;

  modport master (
    output vs_udr, vs_uir, ir_in, sr, act_ready,
    input  act_valid, act_code, jdo, core_sel, bcast, busy, err_overrun, err_timeout
  );

  modport slave (
    input  vs_udr, vs_uir, ir_in, sr, act_ready,
    output act_valid, act_code, jdo, core_sel, bcast, busy, err_overrun, err_timeout
  );
endinterface

// File: rtl/multi_core_debug_dispatch.sv
// Debug command dispatcher: synchronises update strobes, decodes the captured command and
// hands it to one or all cores. Define DBG_DISPATCH_TIMEOUT_EN to enable the ack timeout.
module multi_core_debug_dispatch #(
  parameter int NUM_CORES      = 4,
  parameter int SR_WIDTH       = 38,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                        clk,
  input logic                        reset,
  multi_core_debug_dispatch_if.slave bus
);
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int ARM_W  = SYNC_STAGES + 2;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  // hi carries sr[37:34]; a zero result marks a core-select command
  function automatic logic [3:0] decode_action(input logic [1:0] ir, input logic [3:0] hi,
                                               input logic b15);
    logic [3:0] code;
    case (ir)
      2'd0: code = hi[1] ? 4'd2 : (hi[0] ? 4'd1 : 4'd3);
      2'd1: code = hi[3] ? 4'd5 : (hi[2] ? 4'd4 : 4'd6);
      2'd2: begin
        case (hi[3:2])
          2'b00:   code = 4'd10;
          2'b01:   code = 4'd7;
          2'b10:   code = 4'd8;
          default: code = 4'd9;
        endcase
      end
      2'd3:    code = b15 ? 4'd11 : 4'd0;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic [1:0]             udr_edge_q, uir_edge_q;
  logic [ARM_W-1:0]       arm_q;
  logic                   udr_pulse_q, uir_pulse_q;

  state_e                 state_q;
  logic [NUM_CORES-1:0]   pend_q;
  logic [3:0]             act_code_q;
  logic [SR_WIDTH-1:0]    jdo_q;
  logic [CORE_W-1:0]      core_sel_q;
  logic                   bcast_q;
  logic                   err_overrun_q;
  logic                   err_timeout_q;

  logic [3:0]             cmd_code_s;
  logic [CORE_W-1:0]      sel_idx_s;
  logic                   sel_in_range_s;
  logic [NUM_CORES-1:0]   pend_d;
  logic                   timeout_hit_s;

  // Edge detection is held off until every stage holds a post-reset sample, so a strobe
  // level already high at reset release is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q  <= '0;
      uir_sync_q  <= '0;
      udr_edge_q  <= 2'b00;
      uir_edge_q  <= 2'b00;
      arm_q       <= '0;
      udr_pulse_q <= 1'b0;
      uir_pulse_q <= 1'b0;
    end else begin
      udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], bus.vs_udr};
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], bus.vs_uir};
      udr_edge_q  <= {udr_edge_q[0], udr_sync_q[SYNC_STAGES-1]};
      uir_edge_q  <= {uir_edge_q[0], uir_sync_q[SYNC_STAGES-1]};
      arm_q       <= {arm_q[ARM_W-2:0], 1'b1};
      udr_pulse_q <= udr_edge_q[0] & ~udr_edge_q[1] & arm_q[ARM_W-1];
      uir_pulse_q <= uir_edge_q[0] & ~uir_edge_q[1] & arm_q[ARM_W-1];
    end
  end

  assign cmd_code_s     = decode_action(bus.ir_in, bus.sr[37:34], bus.sr[15]);
  assign sel_idx_s      = bus.sr[CORE_W-1:0];
  assign sel_in_range_s = ({{(32-CORE_W){1'b0}}, sel_idx_s} < 32'(NUM_CORES));
  assign pend_d         = pend_q & ~bus.act_ready;

`ifdef DBG_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;

  // Counts WAIT cycles; held at zero in IDLE so every dispatch starts from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && (pend_d != '0);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Dispatch FSM; error-flag sets are written after the uir clear so a set in the same cycle wins
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      act_code_q    <= 4'd0;
      jdo_q         <= '0;
      core_sel_q    <= '0;
      bcast_q       <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      if (uir_pulse_q) begin
        err_overrun_q <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (udr_pulse_q) begin
            jdo_q <= bus.sr;
            if (cmd_code_s != 4'd0) begin
              act_code_q <= cmd_code_s;
              pend_q     <= bcast_q ? '1 : (NUM_CORES'(1'b1) << core_sel_q);
              state_q    <= S_WAIT;
            end else begin
              bcast_q <= bus.sr[7];
              if (sel_in_range_s) begin
                core_sel_q <= sel_idx_s;
              end
            end
          end
        end
        S_WAIT: begin
          if (udr_pulse_q) begin
            err_overrun_q <= 1'b1;
          end
          if (timeout_hit_s) begin
            pend_q        <= '0;
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            pend_q <= pend_d;
            if (pend_d == '0) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          pend_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.act_valid   = pend_q;
  assign bus.act_code    = act_code_q;
  assign bus.jdo         = jdo_q;
  assign bus.core_sel    = core_sel_q;
  assign bus.bcast       = bcast_q;
  assign bus.busy        = (state_q == S_WAIT);
  assign bus.err_overrun = err_overrun_q;
  assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_multi_core_debug_dispatch.sv
// Directed bench for multi_core_debug_dispatch: a 4-core instance (a) and a 3-core
// instance (b), both with TIMEOUT_CYCLES=16.
module tb_multi_core_debug_dispatch;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  multi_core_debug_dispatch_if #(.NUM_CORES(4), .SR_WIDTH(38)) if_a ();
  multi_core_debug_dispatch_if #(.NUM_CORES(3), .SR_WIDTH(38)) if_b ();

  multi_core_debug_dispatch #(
    .NUM_CORES(4), .SR_WIDTH(38), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );

  multi_core_debug_dispatch #(
    .NUM_CORES(3), .SR_WIDTH(38), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; raises vs_udr for two cycles and returns two edges later
  task automatic udr_go(input bit use_b, input logic [1:0] ir, input logic [37:0] v);
    if (use_b) begin
      if_b.ir_in = ir; if_b.sr = v; if_b.vs_udr = 1'b1;
    end else begin
      if_a.ir_in = ir; if_a.sr = v; if_a.vs_udr = 1'b1;
    end
    repeat (2) @(negedge clk);
    if_a.vs_udr = 1'b0;
    if_b.vs_udr = 1'b0;
  endtask

  task automatic uir_go();
    if_a.vs_uir = 1'b1;
    repeat (2) @(negedge clk);
    if_a.vs_uir = 1'b0;
  endtask

  initial begin
    logic [37:0] v;
    logic [3:0]  remain;
    int          order [4];
    tests = 0;
    fails = 0;
    order = '{0, 3, 1, 2};
    reset = 1'b1;
    if_a.vs_udr = 1'b0; if_a.vs_uir = 1'b0; if_a.ir_in = 2'd0; if_a.sr = '0; if_a.act_ready = '0;
    if_b.vs_udr = 1'b0; if_b.vs_uir = 1'b0; if_b.ir_in = 2'd0; if_b.sr = '0; if_b.act_ready = '0;
    repeat (3) @(negedge clk);
    check("rst_act_valid", 64'(if_a.act_valid), 64'h0);
    check("rst_act_code", 64'(if_a.act_code), 64'h0);
    check("rst_jdo", 64'(if_a.jdo), 64'h0);
    check("rst_busy", 64'(if_a.busy), 64'h0);
    check("rst_flags", 64'({if_a.err_overrun, if_a.err_timeout}), 64'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Single-core dispatch to core 2
    udr_go(1'b0, 2'd3, 38'h2);
    repeat (4) @(negedge clk);
    check("s1_core_sel", 64'(if_a.core_sel), 64'h2);
    check("s1_bcast", 64'(if_a.bcast), 64'h0);
    check("s1_sel_no_busy", 64'(if_a.busy), 64'h0);
    v = 38'h4_0000_1234;
    udr_go(1'b0, 2'd0, v);
    repeat (2) @(negedge clk);
    check("s1_not_yet_valid", 64'(if_a.act_valid), 64'h0);
    @(negedge clk);
    check("s1_act_valid", 64'(if_a.act_valid), 64'h4);
    check("s1_act_code", 64'(if_a.act_code), 64'h1);
    check("s1_jdo", 64'(if_a.jdo), 64'(v));
    check("s1_busy", 64'(if_a.busy), 64'h1);
    repeat (3) @(negedge clk);
    if_a.act_ready = 4'b0100;
    check("s1_held", 64'(if_a.act_valid), 64'h4);
    @(negedge clk);
    if_a.act_ready = 4'b0000;
    check("s1_ack_valid", 64'(if_a.act_valid), 64'h0);
    check("s1_ack_busy", 64'(if_a.busy), 64'h0);

    // Broadcast with acknowledges in order 0,3,1,2
    udr_go(1'b0, 2'd3, 38'h80);
    repeat (4) @(negedge clk);
    check("s2_bcast", 64'(if_a.bcast), 64'h1);
    check("s2_core_sel", 64'(if_a.core_sel), 64'h0);
    v = 38'h30_0000_0055;
    udr_go(1'b0, 2'd2, v);
    repeat (3) @(negedge clk);
    check("s2_act_valid", 64'(if_a.act_valid), 64'hf);
    check("s2_act_code", 64'(if_a.act_code), 64'h9);
    remain = 4'hf;
    for (int k = 0; k < 4; k++) begin
      if_a.act_ready = 4'b0001 << order[k];
      @(negedge clk);
      if_a.act_ready = 4'b0000;
      remain = remain & ~(4'b0001 << order[k]);
      check("s2_ack_mask", 64'(if_a.act_valid), 64'(remain));
      check("s2_ack_busy", 64'(if_a.busy), (k == 3) ? 64'h0 : 64'h1);
    end

    // Overrun while waiting, then cleared by vs_uir
    v = 38'h20_0000_0001;
    udr_go(1'b0, 2'd1, v);
    repeat (3) @(negedge clk);
    check("s3_act_code", 64'(if_a.act_code), 64'h5);
    udr_go(1'b0, 2'd0, 38'hAA);
    repeat (3) @(negedge clk);
    check("s3_overrun", 64'(if_a.err_overrun), 64'h1);
    check("s3_jdo_kept", 64'(if_a.jdo), 64'(v));
    check("s3_code_kept", 64'(if_a.act_code), 64'h5);
    check("s3_still_busy", 64'(if_a.busy), 64'h1);
    if_a.act_ready = 4'hf;
    @(negedge clk);
    if_a.act_ready = 4'h0;
    check("s3_idle", 64'(if_a.busy), 64'h0);
    uir_go();
    repeat (2) @(negedge clk);
    check("s3_overrun_pre_clr", 64'(if_a.err_overrun), 64'h1);
    @(negedge clk);
    check("s3_overrun_clr", 64'(if_a.err_overrun), 64'h0);

    // Overrun strobe landing on the same cycle as the final acknowledge
    udr_go(1'b0, 2'd1, v);
    repeat (3) @(negedge clk);
    check("s3b_busy", 64'(if_a.busy), 64'h1);
    udr_go(1'b0, 2'd0, 38'hBB);
    repeat (2) @(negedge clk);
    if_a.act_ready = 4'hf;
    @(negedge clk);
    if_a.act_ready = 4'h0;
    check("s3b_idle", 64'(if_a.busy), 64'h0);
    check("s3b_overrun", 64'(if_a.err_overrun), 64'h1);
    check("s3b_jdo_kept", 64'(if_a.jdo), 64'(v));
    uir_go();
    repeat (3) @(negedge clk);
    check("s3b_overrun_clr", 64'(if_a.err_overrun), 64'h0);

    // Unacknowledged broadcast
    v = 38'h4_0000_0077;
    udr_go(1'b0, 2'd0, v);
    repeat (3) @(negedge clk);
    check("s4_act_valid", 64'(if_a.act_valid), 64'hf);
`ifdef DBG_DISPATCH_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("s4_pre_timeout", 64'(if_a.act_valid), 64'hf);
    check("s4_pre_timeout_flag", 64'(if_a.err_timeout), 64'h0);
    @(negedge clk);
    check("s4_timeout_valid", 64'(if_a.act_valid), 64'h0);
    check("s4_timeout_busy", 64'(if_a.busy), 64'h0);
    check("s4_timeout_flag", 64'(if_a.err_timeout), 64'h1);
    uir_go();
    repeat (3) @(negedge clk);
    check("s4_timeout_clr", 64'(if_a.err_timeout), 64'h0);
`else
    repeat (10000) @(negedge clk);
    check("s4_held_valid", 64'(if_a.act_valid), 64'hf);
    check("s4_held_busy", 64'(if_a.busy), 64'h1);
    check("s4_no_timeout", 64'(if_a.err_timeout), 64'h0);
    if_a.act_ready = 4'hf;
    @(negedge clk);
    if_a.act_ready = 4'h0;
    check("s4_released", 64'(if_a.busy), 64'h0);
`endif

    // Out-of-range select on the 3-core instance
    udr_go(1'b1, 2'd3, 38'h3);
    repeat (4) @(negedge clk);
    check("s5_sel_unchanged", 64'(if_b.core_sel), 64'h0);
    udr_go(1'b1, 2'd3, 38'h8000);
    repeat (3) @(negedge clk);
    check("s5_act_valid", 64'(if_b.act_valid), 64'h1);
    check("s5_act_code", 64'(if_b.act_code), 64'hb);
    if_b.act_ready = 3'b001;
    @(negedge clk);
    if_b.act_ready = 3'b000;
    check("s5_done", 64'(if_b.busy), 64'h0);
    udr_go(1'b1, 2'd3, 38'h2);
    repeat (4) @(negedge clk);
    udr_go(1'b1, 2'd3, 38'h3);
    repeat (4) @(negedge clk);
    check("s5_sel_kept_2", 64'(if_b.core_sel), 64'h2);
    udr_go(1'b1, 2'd0, 38'h8_0000_0000);
    repeat (3) @(negedge clk);
    check("s5_act_valid_2", 64'(if_b.act_valid), 64'h4);
    check("s5_act_code_2", 64'(if_b.act_code), 64'h2);
    if_b.act_ready = 3'b100;
    @(negedge clk);
    if_b.act_ready = 3'b000;

    // Reset mid-dispatch with vs_udr held high across release
    udr_go(1'b0, 2'd0, v);
    repeat (3) @(negedge clk);
    check("s6_busy_before", 64'(if_a.busy), 64'h1);
    reset = 1'b1;
    if_a.vs_udr = 1'b1;
    @(negedge clk);
    check("s6_act_valid", 64'(if_a.act_valid), 64'h0);
    check("s6_act_code", 64'(if_a.act_code), 64'h0);
    check("s6_jdo", 64'(if_a.jdo), 64'h0);
    check("s6_sel_bcast", 64'({if_a.core_sel, if_a.bcast}), 64'h0);
    check("s6_busy", 64'(if_a.busy), 64'h0);
    check("s6_flags", 64'({if_a.err_overrun, if_a.err_timeout}), 64'h0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("s6_no_dispatch", 64'({if_a.busy, if_a.act_valid}), 64'h0);
    end
    if_a.vs_udr = 1'b0;
    repeat (6) @(negedge clk);
    check("s6_no_dispatch_after_fall", 64'({if_a.busy, if_a.act_valid}), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
